// File: rtl/uart_tool_pkg.sv
// rtl/uart_tool_pkg.sv - shared UART state encodings and bit-timing helpers
package uart_tool_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RECV  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  function automatic int calc_cpb(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

  function automatic int calc_cnt_w(input int cpb);
    return 1 + $clog2(cpb);
  endfunction

endpackage

// File: rtl/uart_tool_rx.sv
// rtl/uart_tool_rx.sv - UART receiver: 2-flop sync, mid-bit sampling, stop check
import uart_tool_pkg::*;

module uart_tool_rx #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_break
);

  localparam int CPB  = calc_cpb(CLK_HZ, BIT_RATE);
  localparam int HALF = CPB / 2;
  localparam int CW   = calc_cnt_w(CPB);
  localparam int BW   = $clog2(PAYLOAD_BITS + 1);

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(PAYLOAD_BITS - 1);

  if (STOP_BITS < 1 || PAYLOAD_BITS < 5 || PAYLOAD_BITS > 8) begin : g_bad_params
    $error("uart_tool_rx: unsupported PAYLOAD_BITS/STOP_BITS");
  end

  logic                    rxd_meta_q;
  logic                    rxd_s_q;
  uart_state_e             state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic                    done;

  always_ff @(posedge clk) begin
    if (!resetn) rxd_meta_q <= 1'b1;
    else         rxd_meta_q <= uart_rxd;
  end

  always_ff @(posedge clk) begin
    if (!resetn) rxd_s_q <= 1'b1;
    else         rxd_s_q <= rxd_meta_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (uart_rx_en && !rxd_s_q) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          // A start bit that is high again at its midpoint was a glitch.
          state_d = rxd_s_q ? ST_IDLE : ST_RECV;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RECV: begin
        if (cnt_q == CPB_M1) begin
          cnt_d   = '0;
          shift_d = {rxd_s_q, shift_q[PAYLOAD_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        // Leave at mid-stop so a following start bit can be caught early.
        if (cnt_q == CPB_M1) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          done    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!uart_rx_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      bit_d   = '0;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    if (!resetn) bit_q <= '0;
    else         bit_q <= bit_d;
  end

  always_ff @(posedge clk) begin
    if (!resetn) shift_q <= '0;
    else         shift_q <= shift_d;
  end

  always_ff @(posedge clk) begin
    if (!resetn) uart_rx_valid <= 1'b0;
    else         uart_rx_valid <= done;
  end

  always_ff @(posedge clk) begin
    if (!resetn)   uart_rx_data <= '0;
    else if (done) uart_rx_data <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn)   uart_rx_frame_err <= 1'b0;
    else if (done) uart_rx_frame_err <= !rxd_s_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn)   uart_rx_break <= 1'b0;
    else if (done) uart_rx_break <= (shift_q == '0) && !rxd_s_q;
  end

endmodule
